// File: rtl/mem_interface.sv
// ---------------------------------------------------------------------------
// mem_interface
//
// MAR/MDR memory interface between the CPU datapath bus and a synchronous
// 512x32 RAM.
//
// Operation:
//   - MAR and MDR are loaded from the datapath bus while the block is idle.
//   - A read or write request starts a RAM access.
//   - The RAM strobe is held for MEM_LATENCY cycles.
//   - Read data is captured into MDR on the last strobe cycle.
//   - A single-cycle Done pulse then goes back to the control unit.
//
// Build option:
//   MEM_BOUNDS_CHECK_EN - when defined, a MAR load with non-zero bits above
//     ADDR_W sets a sticky Fault flag. A request while faulted completes
//     immediately (IDLE -> DONE) without touching the RAM. When undefined,
//     the upper address bits are dropped and Fault is tied low.
//
// Parameters:
//   ADDR_W      RAM address width (MAR width)
//   DATA_W      bus / word width
//   MEM_LATENCY cycles each RAM strobe is held (>= 1)
//
// Ports:
//   Clock        in   system clock, rising edge
//   Clear_n      in   asynchronous active-low reset
//   BusMuxOut    in   datapath bus value
//   MARin        in   load MAR from BusMuxOut[ADDR_W-1:0] (idle only)
//   MDRin        in   load MDR from BusMuxOut (idle only)
//   MemRead_req  in   start a read of RAM[MAR] (idle only)
//   MemWrite_req in   start a write of MDR to RAM[MAR] (idle only)
//   Mdatain      in   read data from the RAM
//   RAM_Read     out  RAM read strobe
//   RAM_Write    out  RAM write strobe
//   RAM_Address  out  current MAR
//   RAM_Data     out  current MDR (RAM write data)
//   MDR_out      out  MDR to the bus mux
//   Busy         out  access in progress (strobe phase)
//   Done         out  one-cycle completion pulse
//   Fault        out  out-of-range address flag
//   state_dbg    out  current FSM state (IDLE=0, RD_WAIT=1, WR_WAIT=2, DONE=3)
//
// Request/completion handshake:
//   - A request is accepted on any rising edge where the FSM is IDLE and
//     MemRead_req or MemWrite_req is high. There is no ready signal:
//     requests presented outside IDLE are simply ignored.
//   - Write has priority when both requests are high.
//   - Completion is signalled by exactly one cycle of Done. The next request
//     can be accepted on the edge that ends the Done cycle's following IDLE
//     cycle, i.e. edge MEM_LATENCY+2 counted from the accepting edge.
// ---------------------------------------------------------------------------
module mem_interface #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic              Clock,
  input  logic              Clear_n,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              MemRead_req,
  input  logic              MemWrite_req,
  input  logic [DATA_W-1:0] Mdatain,
  output logic              RAM_Read,
  output logic              RAM_Write,
  output logic [ADDR_W-1:0] RAM_Address,
  output logic [DATA_W-1:0] RAM_Data,
  output logic [DATA_W-1:0] MDR_out,
  output logic              Busy,
  output logic              Done,
  output logic              Fault,
  output logic [1:0]        state_dbg
);

  // Counter only has to hold MEM_LATENCY-1; keep at least one bit so a
  // latency of 1 still gives a legal vector.
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              bypass;  // request completes without a RAM access

`ifdef MEM_BOUNDS_CHECK_EN
  logic fault_q, fault_d;
  logic addr_oob;

  assign addr_oob = |BusMuxOut[DATA_W-1:ADDR_W];

  // Sticky flag: only a new MAR load (idle only) can change it.
  always_comb begin
    fault_d = fault_q;
    if (state_q == IDLE && MARin) begin
      fault_d = addr_oob;
    end
  end

  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  // A request in the same cycle as a MAR load sees the freshly loaded
  // address, so the bypass decision uses the next-state fault value.
  assign bypass = fault_d;
  assign Fault  = fault_q;
`else
  assign bypass = 1'b0;
  assign Fault  = 1'b0;
`endif

  // Next-state, counter and register-load logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;

    case (state_q)
      IDLE: begin
        // Loads are independent; with both high they share the bus value.
        if (MARin) begin
          mar_d = BusMuxOut[ADDR_W-1:0];
        end
        if (MDRin) begin
          mdr_d = BusMuxOut;
        end
        if (MemWrite_req || MemRead_req) begin
          if (bypass) begin
            state_d = DONE;
          end else if (MemWrite_req) begin
            state_d = WR_WAIT;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = RD_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end

      RD_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // Last strobe cycle: RAM data is valid now.
          mdr_d   = Mdatain;
          state_d = DONE;
        end
      end

      WR_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mar_q   <= '0;
      mdr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
    end
  end

  // Strobes are pure decodes of the state register: no input reaches them
  // combinationally, and an asynchronous reset drops them immediately.
  assign RAM_Read    = (state_q == RD_WAIT);
  assign RAM_Write   = (state_q == WR_WAIT);
  assign Busy        = (state_q == RD_WAIT) || (state_q == WR_WAIT);
  assign Done        = (state_q == DONE);
  assign RAM_Address = mar_q;
  assign RAM_Data    = mdr_q;
  assign MDR_out     = mdr_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_mem_interface.sv
// ---------------------------------------------------------------------------
// tb_mem_interface
//
// Directed bench for mem_interface with MEM_LATENCY = 2.
//   - A behavioural 512x32 RAM model sits behind the DUT.
//   - A table of transactions is applied in order, each record carrying its
//     hand-computed expected strobe counts, Done cycle and final MDR.
//   - Hand-written sequences cover: the reset state, inputs ignored while
//     busy, the bounds-check bypass (MEM_BOUNDS_CHECK_EN), and an abort by
//     reset mid-access.
// ---------------------------------------------------------------------------
module tb_mem_interface;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int LAT    = 2;

  logic              Clock;
  logic              Clear_n;
  logic [DATA_W-1:0] BusMuxOut;
  logic              MARin;
  logic              MDRin;
  logic              MemRead_req;
  logic              MemWrite_req;
  logic [DATA_W-1:0] Mdatain;
  logic              RAM_Read;
  logic              RAM_Write;
  logic [ADDR_W-1:0] RAM_Address;
  logic [DATA_W-1:0] RAM_Data;
  logic [DATA_W-1:0] MDR_out;
  logic              Busy;
  logic              Done;
  logic              Fault;
  logic [1:0]        state_dbg;

  int checks = 0;
  int errors = 0;

  mem_interface #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .MEM_LATENCY(LAT)
  ) dut (
    .Clock       (Clock),
    .Clear_n     (Clear_n),
    .BusMuxOut   (BusMuxOut),
    .MARin       (MARin),
    .MDRin       (MDRin),
    .MemRead_req (MemRead_req),
    .MemWrite_req(MemWrite_req),
    .Mdatain     (Mdatain),
    .RAM_Read    (RAM_Read),
    .RAM_Write   (RAM_Write),
    .RAM_Address (RAM_Address),
    .RAM_Data    (RAM_Data),
    .MDR_out     (MDR_out),
    .Busy        (Busy),
    .Done        (Done),
    .Fault       (Fault),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock ----------------
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // ---------------- RAM model ----------------
  logic [DATA_W-1:0] ram [0:511];

  always @(posedge Clock) begin
    if (RAM_Write) ram[RAM_Address] <= RAM_Data;
  end

  assign Mdatain = ram[RAM_Address];

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- transaction table ----------------
  typedef struct {
    logic        ld_mar;
    logic        ld_mdr;
    logic [31:0] bus_a;
    logic [31:0] bus_d;
    logic        rd;
    logic        wr;
    logic        sep;       // 1: request in its own cycle after the loads
    logic [8:0]  exp_addr;
    logic [31:0] exp_mdr;
    int          exp_rd;
    int          exp_wr;
    int          exp_done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic ld_mar, input logic ld_mdr,
                              input logic [31:0] bus_a, input logic [31:0] bus_d,
                              input logic rd, input logic wr, input logic sep,
                              input logic [8:0] exp_addr, input logic [31:0] exp_mdr,
                              input int exp_rd, input int exp_wr, input int exp_done);
    vec_t v;
    v.ld_mar = ld_mar;  v.ld_mdr = ld_mdr;
    v.bus_a = bus_a;    v.bus_d = bus_d;
    v.rd = rd;          v.wr = wr;            v.sep = sep;
    v.exp_addr = exp_addr;  v.exp_mdr = exp_mdr;
    v.exp_rd = exp_rd;  v.exp_wr = exp_wr;    v.exp_done = exp_done;
    return v;
  endfunction

  // Drives one transaction starting at a negedge with the DUT idle, then
  // watches it to completion. Returns at the negedge of the IDLE cycle
  // after Done.
  task automatic apply(input vec_t v, input int idx);
    bit req_sent = 0;
    int rd_n = 0;
    int wr_n = 0;
    int done_at = 0;
    bit addr_ok = 1;
    bit data_ok = 1;
    bit busy_ok = 1;
    string tag;
    tag = $sformatf("v%0d", idx);

    if (v.ld_mar) begin
      BusMuxOut = v.bus_a;
      MARin = 1'b1;
      if (!v.ld_mdr && !v.sep) begin
        MemRead_req = v.rd; MemWrite_req = v.wr; req_sent = 1;
      end
      @(posedge Clock); @(negedge Clock);
      MARin = 1'b0;
    end
    if (v.ld_mdr && !req_sent) begin
      BusMuxOut = v.bus_d;
      MDRin = 1'b1;
      if (!v.sep) begin
        MemRead_req = v.rd; MemWrite_req = v.wr; req_sent = 1;
      end
      @(posedge Clock); @(negedge Clock);
      MDRin = 1'b0;
    end
    if (!req_sent) begin
      MemRead_req = v.rd; MemWrite_req = v.wr;
      @(posedge Clock); @(negedge Clock);
    end
    MemRead_req = 1'b0;
    MemWrite_req = 1'b0;
    BusMuxOut = '0;

    // Now at the negedge of cycle 1 after the accepting edge.
    for (int k = 1; k <= 12; k++) begin
      if (RAM_Read) rd_n++;
      if (RAM_Write) begin
        wr_n++;
        if (RAM_Data !== v.exp_mdr) data_ok = 0;
      end
      if ((RAM_Read || RAM_Write) && RAM_Address !== v.exp_addr) addr_ok = 0;
      if ((RAM_Read || RAM_Write) && !Busy) busy_ok = 0;
      if (Done) begin
        done_at = k;
        chk({tag, "_busy_at_done"}, 32'(Busy), 32'd0);
        break;
      end
      @(negedge Clock);
    end
    chk({tag, "_done_cycle"}, 32'(done_at), 32'(v.exp_done));
    chk({tag, "_rd_cycles"},  32'(rd_n),    32'(v.exp_rd));
    chk({tag, "_wr_cycles"},  32'(wr_n),    32'(v.exp_wr));
    chk({tag, "_addr"},       32'(addr_ok), 32'd1);
    chk({tag, "_wdata"},      32'(data_ok), 32'd1);
    chk({tag, "_busy"},       32'(busy_ok), 32'd1);
    chk({tag, "_mdr_out"},    MDR_out,      v.exp_mdr);
    chk({tag, "_fault"},      32'(Fault),   32'd0);
    @(negedge Clock);
    chk({tag, "_idle_after"}, 32'(state_dbg), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int done_seen;

    for (int i = 0; i < 512; i++) ram[i] = '0;
    ram[9'h054] = 32'h0000_0097;
    ram[9'h1FF] = 32'hCAFE_F00D;
    ram[9'h000] = 32'h0BAD_F00D;

    Clear_n = 1'b0;
    BusMuxOut = '0;
    MARin = 1'b0;
    MDRin = 1'b0;
    MemRead_req = 1'b0;
    MemWrite_req = 1'b0;

    //                 mar  mdr  bus_a         bus_d         rd   wr   sep  addr    mdr            rd   wr   done
    vecs.push_back(mk(1'b1, 1'b0, 32'h0000_0054, 32'h0,        1'b1, 1'b0, 1'b1, 9'h054, 32'h0000_0097, LAT, 0,   LAT+1));
    vecs.push_back(mk(1'b1, 1'b1, 32'h0000_0092, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, 9'h092, 32'hDEAD_BEEF, 0,   LAT, LAT+1));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 9'h092, 32'hDEAD_BEEF, LAT, 0,   LAT+1));
    vecs.push_back(mk(1'b1, 1'b1, 32'h0000_00A0, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 9'h0A0, 32'h1234_5678, 0,   LAT, LAT+1));
    vecs.push_back(mk(1'b1, 1'b0, 32'h0000_00A0, 32'h0,        1'b1, 1'b0, 1'b0, 9'h0A0, 32'h1234_5678, LAT, 0,   LAT+1));
    vecs.push_back(mk(1'b1, 1'b0, 32'h0000_01FF, 32'h0,        1'b1, 1'b0, 1'b0, 9'h1FF, 32'hCAFE_F00D, LAT, 0,   LAT+1));
    vecs.push_back(mk(1'b1, 1'b1, 32'h0000_0000, 32'h55AA_55AA, 1'b0, 1'b1, 1'b0, 9'h000, 32'h55AA_55AA, 0,   LAT, LAT+1));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 9'h000, 32'h55AA_55AA, LAT, 0,   LAT+1));
`ifndef MEM_BOUNDS_CHECK_EN
    // Upper bus bits are dropped: 0x254 addresses 0x054.
    vecs.push_back(mk(1'b1, 1'b0, 32'h0000_0254, 32'h0,        1'b1, 1'b0, 1'b0, 9'h054, 32'h0000_0097, LAT, 0,   LAT+1));
`endif

    // Reset state while Clear_n is held low.
    repeat (2) @(negedge Clock);
    chk("rst_read",  32'(RAM_Read),  32'd0);
    chk("rst_write", 32'(RAM_Write), 32'd0);
    chk("rst_busy",  32'(Busy),      32'd0);
    chk("rst_done",  32'(Done),      32'd0);
    chk("rst_fault", 32'(Fault),     32'd0);
    chk("rst_addr",  32'(RAM_Address), 32'd0);
    chk("rst_mdr",   MDR_out,        32'd0);
    chk("rst_state", 32'(state_dbg), 32'd0);
    Clear_n = 1'b1;
    @(negedge Clock);

    foreach (vecs[i]) apply(vecs[i], i);
    chk("ram_0a0_written", ram[9'h0A0], 32'h1234_5678);
    chk("ram_092_written", ram[9'h092], 32'hDEAD_BEEF);

    // Inputs ignored while busy: read 0x054, then try to reload MAR and MDR
    // during the strobe phase (MDRin lands on the capture edge).
    BusMuxOut = 32'h0000_0054; MARin = 1'b1; MemRead_req = 1'b1;
    @(posedge Clock); @(negedge Clock);
    MemRead_req = 1'b0; BusMuxOut = 32'h0000_01FF; MARin = 1'b1;
    chk("ign_c1_read", 32'(RAM_Read), 32'd1);
    chk("ign_c1_addr", 32'(RAM_Address), 32'h054);
    @(posedge Clock); @(negedge Clock);
    MARin = 1'b0; MDRin = 1'b1; BusMuxOut = 32'hFFFF_FFFF;
    chk("ign_c2_read", 32'(RAM_Read), 32'd1);
    chk("ign_c2_addr", 32'(RAM_Address), 32'h054);
    @(posedge Clock); @(negedge Clock);
    MDRin = 1'b0; BusMuxOut = '0;
    chk("ign_done", 32'(Done), 32'd1);
    chk("ign_addr_held", 32'(RAM_Address), 32'h054);
    chk("ign_mdr", MDR_out, 32'h0000_0097);
    @(negedge Clock);

`ifdef MEM_BOUNDS_CHECK_EN
    // Out-of-range MAR load sets Fault; a request then bypasses the RAM.
    BusMuxOut = 32'h0000_0200; MARin = 1'b1;
    @(posedge Clock); @(negedge Clock);
    MARin = 1'b0; BusMuxOut = '0;
    chk("bc_fault_set", 32'(Fault), 32'd1);
    MemRead_req = 1'b1;
    @(posedge Clock); @(negedge Clock);
    MemRead_req = 1'b0;
    chk("bc_done_c1", 32'(Done), 32'd1);
    chk("bc_no_read", 32'(RAM_Read), 32'd0);
    chk("bc_no_busy", 32'(Busy), 32'd0);
    @(negedge Clock);
    chk("bc_done_drop", 32'(Done), 32'd0);
    chk("bc_mdr_kept", MDR_out, 32'h0000_0097);
    chk("bc_fault_sticky", 32'(Fault), 32'd1);
    BusMuxOut = 32'h0000_0010; MARin = 1'b1;
    @(posedge Clock); @(negedge Clock);
    MARin = 1'b0; BusMuxOut = '0;
    chk("bc_fault_clr", 32'(Fault), 32'd0);
    chk("bc_addr", 32'(RAM_Address), 32'h010);
`else
    chk("nobc_fault_tied", 32'(Fault), 32'd0);
`endif

    // Abort: reset in the middle of a read.
    BusMuxOut = 32'h0000_0054; MARin = 1'b1; MemRead_req = 1'b1;
    @(posedge Clock); @(negedge Clock);
    MARin = 1'b0; MemRead_req = 1'b0; BusMuxOut = '0;
    chk("abort_pre_read", 32'(RAM_Read), 32'd1);
    #2 Clear_n = 1'b0;
    #1;
    chk("abort_read_low", 32'(RAM_Read), 32'd0);
    chk("abort_busy_low", 32'(Busy), 32'd0);
    chk("abort_mar_zero", 32'(RAM_Address), 32'd0);
    chk("abort_mdr_zero", MDR_out, 32'd0);
    done_seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clock);
      if (Done) done_seen++;
    end
    Clear_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock);
      if (Done) done_seen++;
    end
    chk("abort_no_done", 32'(done_seen), 32'd0);

    // Post-reset read completes normally.
    apply(mk(1'b1, 1'b0, 32'h0000_0054, 32'h0, 1'b1, 1'b0, 1'b0,
             9'h054, 32'h0000_0097, LAT, 0, LAT+1), 99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_interface.md
Name: mem_interface

Overview:
- MAR/MDR memory interface between the CPU datapath bus and the 512x32 RAM.
- Latches the address into MAR and the write data into MDR from the datapath bus.
- Sequences multi-cycle RAM read/write strobes with a latency counter and captures read data into MDR.
- Returns a one-cycle Done pulse to the control unit. Sits directly upstream of the RAM; drives its Read, Write, Address and data-in ports and consumes Mdatain.

Parameters:
ADDR_W, 9, RAM address width; MAR width
DATA_W, 32, bus/word width
MEM_LATENCY, 2, cycles RAM strobe held before read data is valid (legal >=1)

Ports:
Clock  in  1  system clock, rising edge
Clear_n  in  1  asynchronous active-low reset
BusMuxOut  in  DATA_W  datapath bus value
MARin  in  1  load MAR from BusMuxOut[ADDR_W-1:0]
MDRin  in  1  load MDR from BusMuxOut
MemRead_req  in  1  start read of RAM[MAR]
MemWrite_req  in  1  start write of MDR to RAM[MAR]
Mdatain  in  DATA_W  read data from RAM
RAM_Read  out  1  RAM read strobe
RAM_Write  out  1  RAM write strobe
RAM_Address  out  ADDR_W  equals MAR
RAM_Data  out  DATA_W  equals MDR
MDR_out  out  DATA_W  MDR to bus mux
Busy  out  1  transaction in progress
Done  out  1  one-cycle completion pulse
Fault  out  1  out-of-range address flag (see Optional Feature)

Behaviour:
- Clock and reset: single clock domain.
- Clear_n low asynchronously forces:
  - state IDLE
  - MAR=0, MDR=0, counter=0
  - RAM_Read=RAM_Write=Busy=Done=Fault=0
- Reset mid-transaction aborts it: strobes drop immediately, no Done is produced.
- Strobe decoding: RAM_Read, RAM_Write, Busy and Done are decoded combinationally from state. They are glitch-free registered-state decodes with no input paths.
- States: IDLE, RD_WAIT, WR_WAIT, DONE.
- IDLE:
  - MARin and MDRin load on the rising edge; they are independent and both may load in one cycle.
  - MemWrite_req -> WR_WAIT, counter=MEM_LATENCY-1.
  - Else MemRead_req -> RD_WAIT, counter=MEM_LATENCY-1.
  - Both requests asserted together: the write wins and the read is dropped.
  - A request in the same cycle as MARin/MDRin uses the newly loaded values (the register load and the FSM transition share the edge; the strobe starts next cycle).
- RD_WAIT:
  - RAM_Read=1, Busy=1.
  - counter!=0: decrement.
  - counter==0: MDR<=Mdatain, go to DONE.
- WR_WAIT:
  - RAM_Write=1, Busy=1.
  - counter!=0: decrement.
  - counter==0: go to DONE.
- DONE: Done=1, Busy=0, unconditionally -> IDLE.
- Inputs ignored outside IDLE: MARin, MDRin, MemRead_req, MemWrite_req. MAR and MDR are held stable for the whole access.
- Latency: request sampled at edge 0 -> strobe high for exactly MEM_LATENCY cycles -> Done high in cycle MEM_LATENCY+1 -> next request accepted at edge MEM_LATENCY+2.
- MDR_out is valid from the cycle Done is high.
- Widths: MAR takes the low ADDR_W bits of the bus; the counter is wide enough for MEM_LATENCY-1.

Optional Feature:
- Macro: MEM_BOUNDS_CHECK_EN.
- Defined:
  - On a MARin load, if BusMuxOut[DATA_W-1:ADDR_W] != 0, Fault is set (sticky).
  - Fault is cleared by reset or by the next MARin load with an in-range value.
  - A request while Fault=1 goes directly IDLE->DONE: no RAM strobe, MDR unchanged, Done pulses at cycle 1.
- Undefined: upper address bits are truncated silently, Fault is tied 0, no bypass path.

Test Plan:
1. Read, MEM_LATENCY=2: RAM model holds 0x00000097 at 0x054. MARin with bus=0x00000054, then MemRead_req -> RAM_Address=0x054, RAM_Read high 2 cycles, Done at cycle 3, MDR_out=0x00000097, Busy low afterwards.
2. Write then read: MAR=0x092, MDRin with bus=0xDEADBEEF, MemWrite_req -> RAM_Write high 2 cycles, RAM_Data=0xDEADBEEF, Done. A following read of 0x092 -> MDR_out=0xDEADBEEF.
3. Simultaneous MemRead_req and MemWrite_req with MDR=0x12345678 -> only RAM_Write strobes; RAM[MAR]=0x12345678.
4. Ignored inputs while busy: during RD_WAIT drive MARin (bus=0x1FF) and MDRin (bus=0xFFFFFFFF) -> RAM_Address stays at its original value, and MDR ends up holding the read data.
5. Abort: Clear_n pulsed low in RD_WAIT -> RAM_Read=0 within the same cycle, MAR=MDR=0, no Done. Post-reset read of 0x054 completes normally.
6. With MEM_BOUNDS_CHECK_EN: MARin bus=0x00000200 -> Fault=1; MemRead_req -> Done at cycle 1 with no RAM_Read. MARin bus=0x00000010 -> Fault=0.
